// File: rtl/vsm_phase_decoder.sv
// vsm_phase_decoder: decodes one-hot ring-counter phases into a step index,
// checks 0..4 sequencing, counts completed cycles and latches the first fault.
module vsm_phase_decoder #(
  parameter int CNT_W       = 8,
  parameter int STUCK_LIMIT = 1
) (
  input  logic             Phase_Count,
  input  logic             invClear,
  input  logic             Phase0,
  input  logic             Phase1,
  input  logic             Phase2,
  input  logic             Phase3,
  input  logic             Phase4,
  input  logic             Err_Clear,
  output logic [2:0]       Step,
  output logic             Step_Valid,
  output logic             Cycle_Done,
  output logic [CNT_W-1:0] Cycle_Count,
  output logic             Seq_Error,
  output logic [1:0]       Err_Code
);
  typedef enum logic [1:0] {SYNC, TRACK, ERROR} state_t;
  state_t     state;
  logic [4:0] sample;
  logic       one_hot;
  logic [2:0] idx;
  logic [2:0] expected;
  logic [3:0] rep;
  logic [1:0] fault;
  assign sample = {Phase4, Phase3, Phase2, Phase1, Phase0};
  always_comb begin
    one_hot = (sample != 5'd0) && ((sample & (sample - 5'd1)) == 5'd0);
    idx = sample[1] ? 3'd1 : sample[2] ? 3'd2 : sample[3] ? 3'd3 : sample[4] ? 3'd4 : 3'd0;
    // Priority: not one-hot, then in-order, then repeat (stuck past limit), then out of order.
    fault = !one_hot ? 2'b01 :
            idx == expected ? 2'b00 :
            idx == Step ? ((int'(rep) + 1 > STUCK_LIMIT) ? 2'b11 : 2'b00) :
            2'b10;
  end
  always_ff @(posedge Phase_Count or negedge invClear) begin
    if (!invClear) begin
      state       <= SYNC;
      Step        <= 3'd0;
      Step_Valid  <= 1'b0;
      Cycle_Done  <= 1'b0;
      Cycle_Count <= '0;
      Seq_Error   <= 1'b0;
      Err_Code    <= 2'b00;
      expected    <= 3'd0;
      rep         <= 4'd0;
    end else begin
      Cycle_Done <= 1'b0;
      case (state)
        SYNC: if (one_hot && idx == 3'd0) begin
          state      <= TRACK;
          Step       <= 3'd0;
          Step_Valid <= 1'b1;
          expected   <= 3'd1;
          rep        <= 4'd0;
        end
        TRACK: if (fault != 2'b00) begin
          state      <= ERROR;
          Step_Valid <= 1'b0;
          Seq_Error  <= 1'b1;
          Err_Code   <= fault;
        end else if (idx == expected) begin
          Step     <= idx;
          expected <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
          rep      <= 4'd0;
          if (idx == 3'd0) begin
            Cycle_Done  <= 1'b1;
            Cycle_Count <= Cycle_Count + CNT_W'(1);
          end
        end else begin
          rep <= rep + 4'd1;
        end
        ERROR: if (Err_Clear) begin
          state     <= SYNC;
          Seq_Error <= 1'b0;
          Err_Code  <= 2'b00;
        end
        default: state <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_vsm_phase_decoder.sv
// tb_vsm_phase_decoder: directed checks of sequencing, faults, wrap and async reset
// on a CNT_W=2, STUCK_LIMIT=1 instance.
module tb_vsm_phase_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       p0 = 1'b0, p1 = 1'b0, p2 = 1'b0, p3 = 1'b0, p4 = 1'b0;
  logic       err_clear = 1'b0;
  logic [2:0] step;
  logic       step_valid, cycle_done, seq_error;
  logic [1:0] cycle_count, err_code;
  logic [9:0] obs;
  int         passed = 0;
  int         total = 0;
  always #5 clk = ~clk;
  vsm_phase_decoder #(.CNT_W(2), .STUCK_LIMIT(1)) dut (
    .Phase_Count(clk), .invClear(rst_n),
    .Phase0(p0), .Phase1(p1), .Phase2(p2), .Phase3(p3), .Phase4(p4),
    .Err_Clear(err_clear), .Step(step), .Step_Valid(step_valid),
    .Cycle_Done(cycle_done), .Cycle_Count(cycle_count),
    .Seq_Error(seq_error), .Err_Code(err_code)
  );
  // {Step, Step_Valid, Cycle_Done, Cycle_Count, Seq_Error, Err_Code}
  assign obs = {step, step_valid, cycle_done, cycle_count, seq_error, err_code};
  function automatic logic [9:0] ev(input int s, input bit v, input bit d, input int c, input bit e, input int code);
    return {3'(s), v, d, 2'(c), e, 2'(code)};
  endfunction
  function automatic logic [4:0] ph(input int i);
    return 5'd1 << i;
  endfunction
  task automatic drive(input logic [4:0] p, input logic clr);
    @(negedge clk);
    {p4, p3, p2, p1, p0} = p;
    err_clear = clr;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {p4, p3, p2, p1, p0} = 5'd0;
    err_clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    total++;
    if (obs !== ev(0, 0, 0, 0, 0, 0)) $display("FAIL reset: got %b want %b", obs, ev(0, 0, 0, 0, 0, 0));
    else passed++;
  endtask
  task automatic test_clean_sequence();
    int         seq[7] = '{0, 1, 2, 3, 4, 0, 1};
    logic [9:0] want[7];
    want = '{ev(0, 1, 0, 0, 0, 0), ev(1, 1, 0, 0, 0, 0), ev(2, 1, 0, 0, 0, 0), ev(3, 1, 0, 0, 0, 0),
             ev(4, 1, 0, 0, 0, 0), ev(0, 1, 1, 1, 0, 0), ev(1, 1, 0, 1, 0, 0)};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(ph(seq[i]), 1'b0);
      total++;
      if (obs !== want[i]) $display("FAIL clean_seq edge %0d: got %b want %b", i + 1, obs, want[i]);
      else passed++;
    end
  endtask
  task automatic test_not_onehot();
    logic [4:0] pv[5];
    logic [9:0] want[5];
    pv = '{ph(0), ph(1), ph(2), 5'b01100, ph(4)};
    want = '{ev(0, 1, 0, 0, 0, 0), ev(1, 1, 0, 0, 0, 0), ev(2, 1, 0, 0, 0, 0),
             ev(2, 0, 0, 0, 1, 1), ev(2, 0, 0, 0, 1, 1)};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(pv[i], 1'b0);
      total++;
      if (obs !== want[i]) $display("FAIL not_onehot edge %0d: got %b want %b", i + 1, obs, want[i]);
      else passed++;
    end
  endtask
  task automatic test_out_of_order_clear();
    logic [4:0] pv[7];
    logic       cl[7];
    logic [9:0] want[7];
    pv = '{ph(0), ph(1), ph(3), 5'd0, ph(2), ph(3), ph(0)};
    cl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    want = '{ev(0, 1, 0, 0, 0, 0), ev(1, 1, 0, 0, 0, 0), ev(1, 0, 0, 0, 1, 2), ev(1, 0, 0, 0, 0, 0),
             ev(1, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0), ev(0, 1, 0, 0, 0, 0)};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(pv[i], cl[i]);
      total++;
      if (obs !== want[i]) $display("FAIL out_of_order edge %0d: got %b want %b", i + 1, obs, want[i]);
      else passed++;
    end
  endtask
  task automatic test_stuck();
    int         seq[7] = '{0, 1, 2, 3, 3, 3, 3};
    logic       cl[7];
    logic [9:0] want[7];
    cl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    want = '{ev(0, 1, 0, 0, 0, 0), ev(1, 1, 0, 0, 0, 0), ev(2, 1, 0, 0, 0, 0), ev(3, 1, 0, 0, 0, 0),
             ev(3, 1, 0, 0, 0, 0), ev(3, 0, 0, 0, 1, 3), ev(3, 0, 0, 0, 1, 3)};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(ph(seq[i]), cl[i]);
      total++;
      if (obs !== want[i]) $display("FAIL stuck edge %0d: got %b want %b", i + 1, obs, want[i]);
      else passed++;
    end
  endtask
  task automatic test_wrap();
    do_reset();
    drive(ph(0), 1'b0);
    for (int c = 1; c <= 4; c++) begin
      for (int p = 1; p <= 4; p++) drive(ph(p), 1'b0);
      total++;
      if (obs !== ev(4, 1, 0, c - 1, 0, 0)) $display("FAIL wrap pre %0d: got %b want %b", c, obs, ev(4, 1, 0, c - 1, 0, 0));
      else passed++;
      drive(ph(0), 1'b0);
      total++;
      if (obs !== ev(0, 1, 1, c % 4, 0, 0)) $display("FAIL wrap done %0d: got %b want %b", c, obs, ev(0, 1, 1, c % 4, 0, 0));
      else passed++;
    end
  endtask
  task automatic test_async_reset();
    int seq[9] = '{0, 1, 2, 3, 4, 0, 1, 2, 3};
    do_reset();
    for (int i = 0; i < 9; i++) drive(ph(seq[i]), 1'b0);
    total++;
    if (obs !== ev(3, 1, 0, 1, 0, 0)) $display("FAIL async_pre: got %b want %b", obs, ev(3, 1, 0, 1, 0, 0));
    else passed++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== ev(0, 0, 0, 0, 0, 0)) $display("FAIL async_reset: got %b want %b", obs, ev(0, 0, 0, 0, 0, 0));
    else passed++;
    #2;
    rst_n = 1'b1;
    drive(ph(4), 1'b0);
    total++;
    if (obs !== ev(0, 0, 0, 0, 0, 0)) $display("FAIL async_ignore4: got %b want %b", obs, ev(0, 0, 0, 0, 0, 0));
    else passed++;
    drive(ph(0), 1'b0);
    total++;
    if (obs !== ev(0, 1, 0, 0, 0, 0)) $display("FAIL async_resync: got %b want %b", obs, ev(0, 1, 0, 0, 0, 0));
    else passed++;
  endtask
  initial begin
    test_reset();
    test_clean_sequence();
    test_not_onehot();
    test_out_of_order_clear();
    test_stuck();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vsm_phase_decoder.md
# vsm_phase_decoder

Receiving end of the VSM phase bus. Samples the five one-hot phase lines driven by the ring counter, decodes them into a binary step index, checks that the sequence advances 0→1→2→3→4→0 one phase per clock, counts completed instruction cycles and latches the first sequencing fault. It sits between the ring counter and the VSM control logic, which uses Step/Step_Valid instead of raw phase lines.

## Interface

- CNT_W, 8, width of Cycle_Count
- STUCK_LIMIT, 1, consecutive repeated samples of the same phase tolerated before a stuck fault (1..7)

Ports:

- Phase_Count  in  1  clock, rising edge; same clock as the ring counter
- invClear  in  1  asynchronous active-low reset
- Phase0..Phase4  in  1 each  phase lines, expected one-hot
- Err_Clear  in  1  synchronous clear of a latched fault; returns to SYNC
- Step  out  3  binary index (0..4) of the last accepted phase
- Step_Valid  out  1  Step is trusted (TRACK state only)
- Cycle_Done  out  1  one-clock pulse when Phase0 is accepted directly after Phase4
- Cycle_Count  out  CNT_W  completed instruction cycles, wrapping
- Seq_Error  out  1  sticky fault flag
- Err_Code  out  2  first fault: 00 none, 01 not one-hot, 10 out of order, 11 stuck

## Operation

- Reset (invClear=0, asynchronous): state SYNC; Step=0, Step_Valid=0, Cycle_Done=0, Cycle_Count=0, Seq_Error=0, Err_Code=00, expected=0, repeat counter=0.
- Sample = {Phase4..Phase0} at each rising edge. Classified as: invalid (zero or more than one bit set), equal to expected, equal to current Step (repeat), or other.
- SYNC: invalid samples and phases 1..4 are ignored, with no fault. One-hot Phase0 → TRACK, Step=0, Step_Valid=1, expected=1, no Cycle_Done.
- TRACK, priority order:
  - invalid → ERROR, code 01.
  - equal to expected → Step=index, expected=(index+1) mod 5, repeat counter=0. If index=0, Cycle_Done=1 and Cycle_Count+1 (wraps 2^CNT_W−1 → 0).
  - repeat → repeat counter+1; when the counter exceeds STUCK_LIMIT → ERROR, code 11. Step is unchanged.
  - other → ERROR, code 10.
- ERROR: Step_Valid=0, Seq_Error=1, Step holds its last value, and Err_Code holds the first fault (later faults do not overwrite it). Cycle_Count freezes. Err_Clear=1 → SYNC with Seq_Error=0 and Err_Code=00; Cycle_Count is kept.
- Err_Clear in SYNC or TRACK has no effect.
- Cycle_Done is 0 in every clock except the accepting one.

## Timing

- All outputs are registered. A phase sampled at edge n is reflected in the outputs just after edge n (the ring counter's outputs from edge n−1 are stable before edge n). Latency is 1 edge from phase change to Step.
- Fault latency: Seq_Error rises on the edge that samples the offending phase. For a stuck fault, that is the (STUCK_LIMIT+1)-th repeat sample.
- Err_Clear and a fault on the same edge: Err_Clear wins in ERROR (→ SYNC). In TRACK the fault is taken.
- Reset mid-cycle: all outputs return to reset values immediately, without waiting for a clock. After release, the first accepted Phase0 needs one edge.
- Cycle_Count wrap and Cycle_Done on the same edge: Cycle_Count=0 and Cycle_Done=1.

## Test plan

- Reset, then clean sequence 0,1,2,3,4,0,1 over 7 edges → Step 0,1,2,3,4,0,1; Step_Valid=1 from edge 1; Cycle_Done only at edge 6; Cycle_Count=1; Seq_Error=0.
- In TRACK at Step=2, drive Phase2|Phase3 → Seq_Error=1, Err_Code=01, Step_Valid=0, Step=2. Then drive phase 4 → Err_Code stays 01.
- In TRACK at Step=1, drive phase 3 → Err_Code=10. Assert Err_Clear for one edge → SYNC with Seq_Error=0. Phases 2,3 are ignored; Phase0 → Step_Valid=1.
- STUCK_LIMIT=1, at Step=3, hold Phase3 for 3 edges → no fault after the first repeat; Err_Code=11 on the second repeat.
- CNT_W=2, run 4 full cycles → Cycle_Count 1,2,3,0; Cycle_Done pulses 4 times.
- Pull invClear low mid-sequence at Step=3 → all outputs are at reset values before the next edge. After release, phase 4 is ignored and Phase0 → Step_Valid=1, Cycle_Count=0.
